mux_scan_sequencer: RTL and testbench

Sequential front/back end for the 4:1 multiplexer. On a start request it steps the multiplexer select lines through channels 0..3 and waits a programmable settle time on each channel. It samples the multiplexer output for each channel and presents the four samples as one 4-bit word over a valid/ready handshake. It sits upstream of the mux on the select lines (address0, address1) and downstream of it on the data line (mux out).

---
 rtl/mux_scan_pkg.sv | 21 ++
 rtl/mux_scan_sequencer_if.sv | 22 ++
 rtl/mux_scan_sequencer_settle_timer.sv | 31 +++
 rtl/mux_scan_sequencer.sv | 121 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Optional feature macro: SCAN_PARITY_EN (adds word_parity).
package mux_scan_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int ADDR_W       = 2;
  localparam int SETTLE_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Even-parity helper used for the registered word_parity output.
  function automatic logic word_parity_of(input logic [NUM_CHANNELS-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Result-word handshake bundle of the mux scan sequencer.
// Valid/ready rule: the producer raises word_valid with a stable word and
// holds both until a rising edge where word_valid & word_ready are both high;
// that edge transfers the word. word_ready while word_valid is low is ignored.
// Optional feature macro: SCAN_PARITY_EN (adds word_parity to the bundle).
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic [NUM_CHANNELS-1:0] word;
  logic                    word_valid;
  logic                    word_ready;
`ifdef SCAN_PARITY_EN
  logic                    word_parity;

  modport master (output word, output word_valid, output word_parity, input word_ready);
  modport slave  (input word, input word_valid, input word_parity, output word_ready);
`else
  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);
`endif

endinterface

// File: rtl/mux_scan_sequencer_settle_timer.sv
// Loadable settle down-counter. Loaded with SETTLE_CYCLES when a channel is
// entered; done is high on the last settle cycle (count == 1), so the
// sequencer spends exactly SETTLE_CYCLES cycles in SETTLE.
module scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [SETTLE_W-1:0] count;

  // Reload on channel entry, otherwise count down while settling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= SETTLE_W'(SETTLE_CYCLES);
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == SETTLE_W'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: steps the 4:1 mux select through channels 0..3,
// settles SETTLE_CYCLES (legal 1..15) on each, samples mux_out, and offers
// the four samples as one word over the valid/ready bundle.
// Optional feature macro: SCAN_PARITY_EN (registered XOR of the word bits).
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 mux_out,
  output logic                 address0,
  output logic                 address1,
  output logic                 busy,
  output state_t               state,
  mux_scan_sequencer_if.master bus
);

  state_t              state_next;
  logic [ADDR_W-1:0]   ch;
  logic [ADDR_W-1:0]   ch_next;
  logic [NUM_CHANNELS-1:0] shadow;
  logic                load;
  logic                done;
  logic                scanning_next;
  logic                last_ch;

  scan_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .en      (state == SETTLE),
    .done    (done)
  );

  assign last_ch       = (ch == ADDR_W'(NUM_CHANNELS - 1));
  assign scanning_next = (state_next == SETTLE) || (state_next == SAMPLE);

  // Next-state, channel advance and timer reload decisions.
  always_comb begin
    state_next = state;
    ch_next    = ch;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          ch_next    = '0;
          load       = 1'b1;
        end
      end
      SETTLE: begin
        if (done) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (!last_ch) begin
          state_next = SETTLE;
          ch_next    = ch + 1'b1;
          load       = 1'b1;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.word_valid && bus.word_ready) begin
          if (start) begin
            state_next = SETTLE;
            ch_next    = '0;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, channel and registered select/busy outputs (glitch-free address).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      ch                   <= '0;
      {address1, address0} <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_next;
      ch                   <= ch_next;
      {address1, address0} <= scanning_next ? ch_next : '0;
      busy                 <= scanning_next;
    end
  end

  // Per-channel sample capture, result word and handshake flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow         <= '0;
      bus.word       <= '0;
      bus.word_valid <= 1'b0;
`ifdef SCAN_PARITY_EN
      bus.word_parity <= 1'b0;
`endif
    end else if (state == SAMPLE) begin
      shadow[ch] <= mux_out;
      if (last_ch) begin
        bus.word       <= {mux_out, shadow[2:0]};
        bus.word_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
        bus.word_parity <= word_parity_of({mux_out, shadow[2:0]});
`endif
      end
    end else if ((state == HOLD) && bus.word_valid && bus.word_ready) begin
      bus.word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE_CYCLES = 2 and 1), each
// driven by a combinational 4:1 mux model, checked against an arithmetic
// timing model and an expected-word queue.
module tb_mux_scan_sequencer;
  import mux_scan_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start2 = 1'b0, start1 = 1'b0;
  logic [3:0] in2 = 4'b0000, in1 = 4'b0000;
  logic       a0_2, a1_2, a0_1, a1_1, busy2, busy1;
  logic       mux_out2, mux_out1;
  state_t     st2, st1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  mux_scan_sequencer_if bus2();
  mux_scan_sequencer_if bus1();

  // Clock/reset block
  always #5 clk = ~clk;

  assign mux_out2 = in2[{a1_2, a0_2}];
  assign mux_out1 = in1[{a1_1, a0_1}];

  mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .mux_out(mux_out2),
    .address0(a0_2), .address1(a1_2), .busy(busy2), .state(st2), .bus(bus2)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mux_out(mux_out1),
    .address0(a0_1), .address1(a1_1), .busy(busy1), .state(st1), .bus(bus1)
  );

  function automatic logic [1:0] addr_of(input int w);
    return (w == 1) ? {a1_1, a0_1} : {a1_2, a0_2};
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 1) ? busy1 : busy2;
  endfunction
  function automatic logic valid_of(input int w);
    return (w == 1) ? bus1.word_valid : bus2.word_valid;
  endfunction
  function automatic logic [3:0] word_of(input int w);
    return (w == 1) ? bus1.word : bus2.word;
  endfunction
  function automatic state_t state_of(input int w);
    return (w == 1) ? st1 : st2;
  endfunction
`ifdef SCAN_PARITY_EN
  function automatic logic parity_of(input int w);
    return (w == 1) ? bus1.word_parity : bus2.word_parity;
  endfunction
`endif

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 1) start1 = v; else start2 = v;
  endtask

  task automatic set_ready(input int w, input logic v);
    if (w == 1) bus1.word_ready = v; else bus2.word_ready = v;
  endtask

  task automatic set_in(input int w, input logic [3:0] v);
    if (w == 1) in1 = v; else in2 = v;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input int w, input string tag, input logic [3:0] exp_word);
    chk({tag, "_addr"}, 32'(addr_of(w)), 0);
    chk({tag, "_busy"}, 32'(busy_of(w)), 0);
    chk({tag, "_valid"}, 32'(valid_of(w)), 0);
    chk({tag, "_word"}, 32'(word_of(w)), 32'(exp_word));
    chk({tag, "_state"}, 32'(state_of(w)), 32'(IDLE));
`ifdef SCAN_PARITY_EN
    chk({tag, "_parity"}, 32'(parity_of(w)), 32'(^exp_word));
`endif
  endtask

  // Called #1 after the edge that accepted start. Each channel occupies
  // s+1 cycles, so after edge k+t the select is t/(s+1); the word appears
  // after edge k+4(s+1).
  task automatic scan_check(input int w, input int s, input bit rand_ready);
    logic [3:0] exp_word;
    int n;
    n = 4 * (s + 1);
    exp_word = exp_q.pop_front();
    for (int t = 0; t < n; t++) begin
      chk("scan_addr", 32'(addr_of(w)), 32'(t / (s + 1)));
      chk("scan_busy", 32'(busy_of(w)), 1);
      chk("scan_valid_low", 32'(valid_of(w)), 0);
      if (rand_ready) set_ready(w, 1'($urandom_range(0, 1)));
      tick();
    end
    if (rand_ready) set_ready(w, 1'b0);
    chk("done_valid", 32'(valid_of(w)), 1);
    chk("done_word", 32'(word_of(w)), 32'(exp_word));
    chk("done_busy", 32'(busy_of(w)), 0);
    chk("done_addr", 32'(addr_of(w)), 0);
    chk("done_state", 32'(state_of(w)), 32'(HOLD));
`ifdef SCAN_PARITY_EN
    chk("done_parity", 32'(parity_of(w)), 32'(^exp_word));
`endif
  endtask

  task automatic accept(input int w);
    set_ready(w, 1'b1);
    tick();
    set_ready(w, 1'b0);
    chk("accept_valid", 32'(valid_of(w)), 0);
    chk("accept_state", 32'(state_of(w)), 32'(IDLE));
  endtask

  initial begin
    logic [3:0] pat;
    bus2.word_ready = 1'b0;
    bus1.word_ready = 1'b0;

    // Reset held 3 cycles with start high: everything stays at reset values.
    in2 = 4'b1010;
    start2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle_outputs(2, "rst2", 4'b0000);
      chk_idle_outputs(1, "rst1", 4'b0000);
    end

    // Release: scan starts at the first edge with reset_n high (basic scan).
    reset_n = 1'b1;
    exp_q.push_back(in2);
    tick();
    start2 = 1'b0;
    chk("release_state", 32'(st2), 32'(SETTLE));
    scan_check(2, 2, 1'b0);

    // Backpressure: word held, inputs change, start ignored.
    in2 = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      start2 = 1'($urandom_range(0, 1));
      tick();
      chk("bp_valid", 32'(bus2.word_valid), 1);
      chk("bp_word", 32'(bus2.word), 32'hA);
      chk("bp_addr", 32'({a1_2, a0_2}), 0);
      chk("bp_busy", 32'(busy2), 0);
    end
    start2 = 1'b0;
    accept(2);
    chk("bp_word_kept", 32'(bus2.word), 32'hA);

    // Back-to-back: start and ready held high, one HOLD cycle between words.
    in2 = 4'b0111;
    start2 = 1'b1;
    bus2.word_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(in2);
    tick();
    scan_check(2, 2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("b2b_state", 32'(st2), 32'(SETTLE));
      scan_check(2, 2, 1'b0);
    end
    start2 = 1'b0;
    tick();
    bus2.word_ready = 1'b0;
    chk("b2b_end_state", 32'(st2), 32'(IDLE));
    chk("b2b_end_valid", 32'(bus2.word_valid), 0);

    // SETTLE_CYCLES = 1: 8-cycle scan, stray ready pulses while not valid.
    in1 = 4'b1100;
    exp_q.push_back(in1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    scan_check(1, 1, 1'b1);
    accept(1);

    // Randomized scans on both instances, random hold time before accept.
    for (int i = 0; i < 8; i++) begin
      int w;
      int s;
      w = (i % 2 == 0) ? 2 : 1;
      s = (w == 2) ? 2 : 1;
      pat = 4'($urandom_range(0, 15));
      set_in(w, pat);
      exp_q.push_back(pat);
      set_start(w, 1'b1);
      tick();
      set_start(w, 1'b0);
      scan_check(w, s, 1'b1);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        tick();
        chk("rnd_hold_valid", 32'(valid_of(w)), 1);
        chk("rnd_hold_word", 32'(word_of(w)), 32'(pat));
      end
      accept(w);
    end

    // Reset mid-scan during channel-2 settle: immediate abort, no word.
    in2 = 4'b1111;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    chk("mid_addr_before", 32'({a1_2, a0_2}), 2);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs(2, "midrst", 4'b0000);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle_outputs(2, "post_rst", 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
